// File: rtl/spi_slave_dma_tx.sv
// SPI slave transmitter: prefetches a memory block over a qpimem_arb read port into a
// local FIFO and shifts it out LSB-first on MISO in SPI mode 0.
module spi_slave_dma_tx #(
    parameter int FIFO_WORDS  = 64,
    parameter int BURST_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        bus_cyc,
    input  logic        bus_we,
    output logic        bus_ack,
    output logic        qpimem_arb_do_read,
    input  logic        qpimem_arb_next_word,
    output logic [31:0] qpimem_arb_addr,
    input  logic [31:0] qpimem_arb_rdata,
    input  logic        SCK,
    input  logic        CS,
    output logic        MISO
);
    localparam int AW = $clog2(FIFO_WORDS);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_WORDS + 1);

    typedef enum logic [1:0] {F_IDLE, F_BURST, F_DONE} fetch_state_t;
    typedef enum logic [1:0] {T_IDLE, T_ACTIVE, T_DRAIN} tx_state_t;

    logic [31:0]  r_rdata, r_src_addr, r_word_limit, r_words_sent, r_words_fetched, r_fetch_addr;
    logic [31:0]  r_shift;
    logic         r_ack, r_enable, r_underrun, r_fetch_done, r_in_txn, r_do_read, r_miso;
    logic [2:0]   r_cs_sync, r_sck_sync;
    logic [BW-1:0] r_burst_left;
    logic [4:0]   r_bit_cnt;
    fetch_state_t r_fstate;
    tx_state_t    r_tstate;
    logic [31:0]  r_mem [FIFO_WORDS];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;

    logic        w_wr, w_arm, w_disable, w_run;
    logic [31:0] w_src_next, w_rdata_mux, w_remain, w_burst_len, w_free, w_sent_next, w_head;
    logic        w_fetch_done_now, w_push, w_pop, w_load, w_word_end, w_limit_hit, w_empty;
    logic        w_cs_fall, w_cs_rise, w_sck_fall;

    assign bus_rdata          = r_rdata;
    assign bus_ack            = r_ack;
    assign qpimem_arb_do_read = r_do_read;
    assign qpimem_arb_addr    = r_fetch_addr;
    assign MISO               = r_miso;

    // Arming and disabling both flush the datapath; in those cycles nothing else advances.
    assign w_wr       = bus_cyc & bus_we;
    assign w_arm      = w_wr & (((bus_addr == 3'd1) & r_enable) | ((bus_addr == 3'd0) & bus_wdata[0] & ~r_enable));
    assign w_disable  = w_wr & (bus_addr == 3'd0) & ~bus_wdata[0] & r_enable;
    assign w_run      = r_enable & ~(w_arm | w_disable);
    assign w_src_next = (w_wr && bus_addr == 3'd1) ? bus_wdata : r_src_addr;

    assign w_cs_fall  = r_cs_sync[2] & ~r_cs_sync[1];
    assign w_cs_rise  = ~r_cs_sync[2] & r_cs_sync[1];
    assign w_sck_fall = r_sck_sync[2] & ~r_sck_sync[1];

    assign w_remain         = r_word_limit - r_words_fetched;
    assign w_burst_len      = (r_word_limit == 32'd0 || w_remain >= 32'(BURST_WORDS)) ? 32'(BURST_WORDS) : w_remain;
    assign w_free           = 32'(FIFO_WORDS - 1) - 32'(r_count);
    assign w_fetch_done_now = (r_word_limit != 32'd0) && (r_words_fetched == r_word_limit);
    assign w_push           = w_run & (r_fstate == F_BURST) & qpimem_arb_next_word;

    assign w_word_end  = w_run & ~w_cs_rise & (r_tstate == T_ACTIVE) & w_sck_fall & (r_bit_cnt == 5'd31);
    assign w_sent_next = r_words_sent + 32'(w_word_end);
    assign w_load      = w_run & ~w_cs_rise & (((r_tstate == T_IDLE) & w_cs_fall) | w_word_end);
    assign w_limit_hit = (r_word_limit != 32'd0) && (w_sent_next == r_word_limit);
    assign w_empty     = (r_count == '0);
    assign w_pop       = w_load & ~w_limit_hit & ~w_empty;
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_rdata_mux = 32'd0;
        case (bus_addr)
            3'd0:    w_rdata_mux = {27'd0, r_fetch_done, r_in_txn, r_underrun, ~r_cs_sync[1], r_enable};
            3'd1:    w_rdata_mux = r_src_addr;
            3'd2:    w_rdata_mux = r_words_sent;
            3'd3:    w_rdata_mux = r_word_limit;
            default: w_rdata_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack        <= 1'b0;
            r_rdata      <= 32'd0;
            r_enable     <= 1'b0;
            r_src_addr   <= 32'd0;
            r_word_limit <= 32'd0;
        end else begin
            r_ack <= bus_cyc & ~r_ack;
            if (bus_cyc) begin
                r_rdata <= w_rdata_mux;
                if (bus_we) begin
                    case (bus_addr)
                        3'd0:    r_enable     <= bus_wdata[0];
                        3'd1:    r_src_addr   <= bus_wdata;
                        3'd3:    r_word_limit <= bus_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    // CS idles high so the synchroniser resets to 1 to avoid a phantom falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync  <= 3'b111;
            r_sck_sync <= 3'b000;
        end else begin
            r_cs_sync  <= {r_cs_sync[1:0], CS};
            r_sck_sync <= {r_sck_sync[1:0], SCK};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fstate        <= F_IDLE;
            r_do_read       <= 1'b0;
            r_fetch_addr    <= 32'd0;
            r_words_fetched <= 32'd0;
            r_fetch_done    <= 1'b0;
            r_burst_left    <= '0;
        end else if (w_arm) begin
            r_fstate        <= F_IDLE;
            r_do_read       <= 1'b0;
            r_fetch_addr    <= w_src_next;
            r_words_fetched <= 32'd0;
            r_fetch_done    <= 1'b0;
        end else if (!w_run) begin
            r_fstate  <= F_IDLE;
            r_do_read <= 1'b0;
        end else begin
            case (r_fstate)
                F_IDLE: begin
                    if (w_fetch_done_now) begin
                        r_fstate     <= F_DONE;
                        r_fetch_done <= 1'b1;
                    end else if (w_free >= w_burst_len) begin
                        r_fstate     <= F_BURST;
                        r_do_read    <= 1'b1;
                        r_burst_left <= w_burst_len[BW-1:0];
                    end
                end
                F_BURST: begin
                    if (qpimem_arb_next_word) begin
                        r_fetch_addr    <= r_fetch_addr + 32'd4;
                        r_words_fetched <= r_words_fetched + 32'd1;
                        r_burst_left    <= r_burst_left - BW'(1);
                        if (r_burst_left == BW'(1)) begin
                            r_do_read <= 1'b0;
                            r_fstate  <= F_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= qpimem_arb_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset || !w_run) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // A word is loaded at CS fall and after every 32nd SCK fall; the limit check uses the post-increment count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tstate     <= T_IDLE;
            r_shift      <= 32'd0;
            r_miso       <= 1'b0;
            r_bit_cnt    <= 5'd0;
            r_in_txn     <= 1'b0;
            r_words_sent <= 32'd0;
            r_underrun   <= 1'b0;
        end else if (!w_run) begin
            r_tstate <= T_IDLE;
            r_miso   <= 1'b0;
            r_in_txn <= 1'b0;
            if (w_arm) begin
                r_words_sent <= 32'd0;
                r_underrun   <= 1'b0;
            end
        end else if (w_cs_rise) begin
            r_tstate <= T_IDLE;
            r_miso   <= 1'b0;
            r_in_txn <= 1'b0;
        end else begin
            if (w_word_end) r_words_sent <= w_sent_next;
            if (w_load) begin
                r_bit_cnt <= 5'd0;
                r_in_txn  <= 1'b1;
                if (w_limit_hit) begin
                    r_tstate <= T_DRAIN;
                    r_shift  <= 32'd0;
                    r_miso   <= 1'b0;
                end else if (w_empty) begin
                    r_tstate   <= T_ACTIVE;
                    r_shift    <= 32'd0;
                    r_miso     <= 1'b0;
                    r_underrun <= 1'b1;
                end else begin
                    r_tstate <= T_ACTIVE;
                    r_shift  <= w_head;
                    r_miso   <= w_head[0];
                end
            end else if (r_tstate == T_ACTIVE && w_sck_fall) begin
                r_shift   <= r_shift >> 1;
                r_miso    <= r_shift[1];
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end
endmodule
